// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver; one digit advances per scan tick.
// Optional leading-zero blanking is built when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [IDX_W-1:0]    idx_q, idx_d, idx_next;
    logic [4*DIGITS-1:0] snap_val_q, snap_val_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                started_q, started_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_done_q, frame_done_d;

    logic [4*DIGITS-1:0] src_val;
    logic [DIGITS-1:0]   src_dp;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                hi_zero;
`endif

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        // Digit 0 opens a new frame, so it reads the live inputs being captured this edge.
        src_val  = (idx_next == '0) ? value : snap_val_q;
        src_dp   = (idx_next == '0) ? dp_in : snap_dp_q;

        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_next) begin
                nib    = src_val[4*i +: 4];
                dp_sel = src_dp[i];
            end
        end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) >= idx_next && src_val[4*i +: 4] != 4'h0)
                hi_zero = 1'b0;
        end
        blank = (idx_next != '0) && hi_zero;
`else
        blank = 1'b0;
`endif

        idx_d        = idx_q;
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        started_d    = started_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;

        if (tick) begin
            idx_d     = idx_next;
            started_d = 1'b1;
            if (idx_next == '0) begin
                snap_val_d = value;
                snap_dp_d  = dp_in;
            end
            an_d         = blank ? '1 : ~(DIGITS'(1) << idx_next);
            seg_d        = blank ? 7'h7F : decode(nib);
            dp_d         = blank | ~dp_sel;
            frame_done_d = (idx_next == LAST_IDX) && started_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= LAST_IDX;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            started_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            started_q    <= started_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed 7-segment display driver. It consumes a one-cycle scan strobe from the clock-divider tick generator (nominally 500 Hz from the 50 MHz clock).
- On each strobe it advances to the next digit, drives that digit's anode and decoded hex segments, and snapshots the display value once per frame so digits never tear.
- It sits between datapath registers and the board's common-anode display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 2..8.
- IDX_W, 3, digit-index width; must satisfy 2**IDX_W >= DIGITS.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- tick  input  1  scan strobe, high for exactly one clk cycle per scan step
- value  input  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 = least significant (rightmost)
- dp_in  input  DIGITS  decimal-point request per digit, active-high
- an  output  DIGITS  digit anodes, active-low, one-hot-low or all high
- seg  output  7  segments {g,f,e,d,c,b,a} = seg[6:0], active-low
- dp  output  1  decimal point, active-low
- frame_done  output  1  one-cycle pulse after the last digit of a frame is driven

Behaviour:
- Reset (async, immediate on rst high):
  - idx = DIGITS-1; an = all 1s; seg = 7'h7F; dp = 1; frame_done = 0; snapshot registers = 0; started = 0.
  - The display stays dark until the first tick.
- State:
  - idx counter, snapshot of value/dp_in, started flag.
  - Everything is idle between ticks; registers hold their values when tick = 0.
- On a clk edge with tick = 1:
  - idx_next = (idx == DIGITS-1) ? 0 : idx+1.
  - If idx_next == 0, value and dp_in are captured into the snapshot on this same edge. Digit 0 of the new frame is decoded from the live inputs, not the stale snapshot.
  - an: bit idx_next is driven low, all other bits high.
  - seg is the decode of nibble idx_next; dp = ~dp_in bit idx_next (from the same source as seg).
  - started is set to 1.
- Latency: an/seg/dp change on the clk edge that samples tick and are visible the cycle after tick is high. There is no additional pipeline.
- frame_done:
  - Asserts for exactly one cycle, on the edge that samples a tick when idx_next == DIGITS-1 and started was already 1 or becomes 1.
  - It therefore coincides with the outputs first showing the MSD.
- Decode (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - The decode is combinational from the selected nibble and registered into seg.
- Boundary conditions:
  - Ticks on consecutive cycles are legal: each one advances one digit.
  - Changes to value mid-frame do not affect digits 1..DIGITS-1 until the next frame.
  - Wrap is from DIGITS-1 to 0 only; idx never exceeds DIGITS-1.
  - If rst asserts mid-frame, outputs go dark immediately. The first tick after release drives digit 0 with a fresh snapshot.
  - an is never more than one bit low.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i >= 1) is blanked when nibbles DIGITS-1 down to i of its source (live inputs for digit 0 frame start, otherwise the snapshot) are all zero.
  - Blanked digit: its an bit stays high, seg = 7'h7F, dp = 1.
  - The idx/frame_done timing is unchanged.
  - Digit 0 is never blanked.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- Reset then rst=0, no tick for 100 cycles -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 throughout.
- value=16'h12AF, dp_in=4'b0100, 4 ticks spaced 10 cycles -> an sequence E,D,B,7 with seg 0E,08,24,79; dp=0 only with an=B; frame_done pulse one cycle with an=7.
- Mid-frame change: after tick 1 with value=16'h1234, set value=16'h5678 -> digits 1..3 show 3,2,1; the next frame's digit 0 shows 8 and then 7,6,5.
- Back-to-back ticks (tick held 1 for 5 cycles) -> an walks E,D,B,7,E on consecutive cycles; exactly one frame_done pulse.
- rst pulse while an=B -> an=F and seg=7F asynchronously; the next tick gives an=E.
- With SEG7_LEADING_ZERO_BLANK_EN and value=16'h0070 -> digit 0 shows 40, digit 1 shows 78, digits 2 and 3 keep their an bits high with seg=7F; value=16'h0000 -> only digit 0 lit, showing 40.
